// File: rtl/motor_pkg.sv
// Shared keyboard codes, drive polarity and sequencer state encoding for the
// multi-channel motor sequencer.
package motor_pkg;

  localparam logic [7:0] KEY_CH0 = 8'h1d;
  localparam logic [7:0] KEY_ALL = 8'h15;

  localparam logic MOTOR_ON  = 1'b0;
  localparam logic MOTOR_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MANUAL  = 2'd1,
    PATTERN = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks, restartable
// with clr so the next interval is a full CLK_DIV long.
module tick_gen #(
  parameter int CLK_DIV = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/motor_sequencer.sv
// N-channel motor sequencer: manual drive from held scancodes, or a
// tick-timed, phase-staggered on/off pattern started by a rising `released`.
module motor_sequencer
  import motor_pkg::*;
#(
  parameter int NUM_MOTORS = 3,
  parameter int CLK_DIV    = 2700000,
  parameter int PERIOD     = 20,
  parameter int ON_START   = 11,
  parameter int ON_END     = 19,
  parameter int PHASE_STEP = 0,
  parameter int REPEATS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data,
  input  logic                  released,
  input  logic [NUM_MOTORS-1:0] ch_en,
  output logic [NUM_MOTORS-1:0] motor_n,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = $clog2(PERIOD);
  localparam int PW = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST   = SW'(PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(REPEATS - 1);

  state_t          state, state_next;
  logic [SW-1:0]   step, step_next;
  logic [PW-1:0]   period, period_next;
  logic            released_q;
  logic            rise;
  logic            key_hit;
  logic            tick;
  logic            clr;
  logic [NUM_MOTORS-1:0] pat_on;
  logic [NUM_MOTORS-1:0] on_vec;
  logic [NUM_MOTORS-1:0] motor_next;

  assign rise    = released & ~released_q;
  assign key_hit = (data == KEY_CH0) || (data == KEY_ALL);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_next  = state;
    step_next   = step;
    period_next = period;
    clr         = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_next = PATTERN;
        end else if (key_hit) begin
          state_next = MANUAL;
        end
      end
      MANUAL: begin
        if (rise) begin
          state_next = PATTERN;
        end else if (!key_hit) begin
          state_next = IDLE;
        end
      end
      PATTERN: begin
        // Abort wins over a tick arriving in the same cycle.
        if (!released) begin
          state_next = IDLE;
        end else if (tick) begin
          if (step == STEP_LAST) begin
            step_next = '0;
            if (period == PERIOD_LAST) begin
              state_next = DONE;
            end else begin
              period_next = period + 1'b1;
            end
          end else begin
            step_next = step + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next == PATTERN && state != PATTERN) begin
      step_next   = '0;
      period_next = '0;
      clr         = 1'b1;
    end
  end

  // Per-channel phase: constant offset folded mod PERIOD at elaboration,
  // so the runtime wrap is a single compare-and-subtract.
  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_phase
    localparam int OFF = (i * PHASE_STEP) % PERIOD;
    logic [SW:0] sum;
    logic [SW:0] ph;
    assign sum = {1'b0, step_next} + (SW+1)'(OFF);
    assign ph  = (sum >= (SW+1)'(PERIOD)) ? sum - (SW+1)'(PERIOD) : sum;
    assign pat_on[i] = (ph >= (SW+1)'(ON_START)) && (ph <= (SW+1)'(ON_END));
  end

  always_comb begin
    on_vec = '0;
    unique case (state_next)
      MANUAL: begin
        if (data == KEY_ALL) begin
          on_vec = '1;
        end else begin
          on_vec[0] = 1'b1;
        end
      end
      PATTERN: on_vec = pat_on;
      default: on_vec = '0;
    endcase
    for (int i = 0; i < NUM_MOTORS; i++) begin
      motor_next[i] = (on_vec[i] && ch_en[i]) ? MOTOR_ON : MOTOR_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      period     <= '0;
      released_q <= 1'b0;
      motor_n    <= {NUM_MOTORS{MOTOR_OFF}};
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      period     <= period_next;
      released_q <= released;
      motor_n    <= motor_next;
      busy       <= (state_next == PATTERN);
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// Scoreboard bench: two sequencers (in-phase and staggered) share stimulus;
// expected outputs come from a cycle-count reference model.
module tb_motor_sequencer;

  localparam int NM       = 3;
  localparam int CLK_DIV  = 4;
  localparam int PERIOD   = 4;
  localparam int ON_START = 1;
  localparam int ON_END   = 2;
  localparam int REPEATS  = 2;
  localparam int TOTAL    = CLK_DIV * PERIOD * REPEATS;

  localparam int M_IDLE = 0;
  localparam int M_MAN  = 1;
  localparam int M_PAT  = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          released = 1'b0;
  logic [NM-1:0] ch_en = '1;
  logic [NM-1:0] motor_n0, motor_n1;
  logic          busy0, busy1, done0, done1;

  int total = 0;
  int bad   = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];

  int m_mode = M_IDLE;
  int m_k    = 0;
  bit m_relq = 1'b0;

  always #5 clk = ~clk;

  motor_sequencer #(
    .NUM_MOTORS (NM), .CLK_DIV (CLK_DIV), .PERIOD (PERIOD),
    .ON_START (ON_START), .ON_END (ON_END), .PHASE_STEP (0), .REPEATS (REPEATS)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .data (data), .released (released),
    .ch_en (ch_en), .motor_n (motor_n0), .busy (busy0), .done (done0)
  );

  motor_sequencer #(
    .NUM_MOTORS (NM), .CLK_DIV (CLK_DIV), .PERIOD (PERIOD),
    .ON_START (ON_START), .ON_END (ON_END), .PHASE_STEP (1), .REPEATS (REPEATS)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .data (data), .released (released),
    .ch_en (ch_en), .motor_n (motor_n1), .busy (busy1), .done (done1)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got motor_n/busy/done=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] expect_out(input int ps, input logic [7:0] d,
                                            input logic [NM-1:0] e);
    logic [NM-1:0] on;
    int s, ph;
    on = '0;
    if (m_mode == M_MAN) begin
      if (d == 8'h15) on = '1;
      else on[0] = 1'b1;
    end else if (m_mode == M_PAT) begin
      s = (m_k / CLK_DIV) % PERIOD;
      for (int i = 0; i < NM; i++) begin
        ph = (s + i * ps) % PERIOD;
        on[i] = (ph >= ON_START) && (ph <= ON_END);
      end
    end
    return {~(on & e), m_mode == M_PAT, m_mode == M_DONE};
  endfunction

  task automatic model_step(input logic [7:0] d, input logic r, input logic [NM-1:0] e);
    bit rise, key;
    rise = r && !m_relq;
    key  = (d == 8'h1d) || (d == 8'h15);
    case (m_mode)
      M_IDLE: if (rise) begin m_mode = M_PAT; m_k = 0; end
              else if (key) m_mode = M_MAN;
      M_MAN:  if (rise) begin m_mode = M_PAT; m_k = 0; end
              else if (!key) m_mode = M_IDLE;
      M_PAT:  if (!r) m_mode = M_IDLE;
              else if (m_k + 1 == TOTAL) m_mode = M_DONE;
              else m_k++;
      default: m_mode = M_IDLE;
    endcase
    m_relq = r;
    q0.push_back(expect_out(0, d, e));
    q1.push_back(expect_out(1, d, e));
  endtask

  task automatic cyc(input logic [7:0] d, input logic r, input logic [NM-1:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      data = d; released = r; ch_en = e;
      model_step(d, r, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    data = 8'h00; released = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_dut0", {motor_n0, busy0, done0}, 5'b11100);
    check("async_reset_dut1", {motor_n1, busy1, done1}, 5'b11100);
    repeat (2) @(negedge clk);
    check("hold_reset_dut0", {motor_n0, busy0, done0}, 5'b11100);
    #1;
    rst_n = 1'b1;
    m_mode = M_IDLE; m_k = 0; m_relq = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check("dut0_out", {motor_n0, busy0, done0}, q0.pop_front());
    if (q1.size() > 0) check("dut1_out", {motor_n1, busy1, done1}, q1.pop_front());
  end

  initial begin
    logic [7:0] rd;
    logic       rr;
    logic [NM-1:0] re;
    repeat (3) @(negedge clk);
    check("por_dut0", {motor_n0, busy0, done0}, 5'b11100);
    check("por_dut1", {motor_n1, busy1, done1}, 5'b11100);
    #1 rst_n = 1'b1;

    cyc(8'h00, 1'b0, 3'b111, 3);
    cyc(8'h1d, 1'b0, 3'b111, 3);
    cyc(8'h15, 1'b0, 3'b111, 3);
    cyc(8'h00, 1'b0, 3'b111, 2);
    cyc(8'h00, 1'b1, 3'b111, 40);
    cyc(8'h00, 1'b0, 3'b111, 3);
    cyc(8'h00, 1'b1, 3'b111, 10);
    cyc(8'h00, 1'b0, 3'b111, 3);
    cyc(8'h00, 1'b1, 3'b101, 40);
    cyc(8'h00, 1'b0, 3'b111, 3);
    cyc(8'h15, 1'b1, 3'b111, 7);
    do_reset();
    cyc(8'h1d, 1'b0, 3'b111, 2);
    cyc(8'h00, 1'b0, 3'b111, 2);

    rd = 8'h00; rr = 1'b0; re = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rr = ~rr;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rd = 8'h1d;
          1: rd = 8'h15;
          2: rd = 8'h00;
          default: rd = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) re = NM'($urandom);
      cyc(rd, rr, re, 1);
    end
    cyc(8'h00, 1'b0, 3'b111, 3);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
- Parametrised N-channel motor driver, fed by decoded keyboard scancodes from the PS/2 front end.
- Manual mode: a held key drives one channel, or all channels, immediately.
- Pattern mode: asserting `released` starts a tick-timed on/off pattern, phase-staggered per channel, for a fixed number of periods.
- Sits between the keyboard decoder and the active-low motor driver pins; successor to the fixed 3-motor controller.

Parameters:
- NUM_MOTORS, 3, number of motor channels (1..8).
- CLK_DIV, 2700000, clk cycles per pattern step tick (>=2).
- PERIOD, 20, steps per pattern period (>=2).
- ON_START, 11, first step of the on-window within a period (< PERIOD).
- ON_END, 19, last step of the on-window, inclusive (ON_START <= ON_END < PERIOD).
- PHASE_STEP, 0, step offset added per channel index (0 = all channels in phase).
- REPEATS, 3, periods executed per pattern run (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, synchronous release; active-low.
- data  in  8  current scancode, level-held by the decoder.
- released  in  1  pattern request level; rising edge starts a run, low aborts it.
- ch_en  in  NUM_MOTORS  per-channel enable; a disabled channel always outputs 1.
- motor_n  out  NUM_MOTORS  active-low motor drive (0 = motor on).
- busy  out  1  high while in PATTERN.
- done  out  1  one-cycle pulse when a run completes normally.

Behaviour:
- Reset (async, rst_n=0):
  - motor_n = all 1s, busy = 0, done = 0.
  - state = IDLE; prescaler, step, period counters and released_q = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1. `tick` = 1-cycle pulse when count == CLK_DIV-1, then wraps to 0.
  - Runs free in all states; reset to 0 on entering PATTERN so the first step lasts a full CLK_DIV.
- States: IDLE, MANUAL, PATTERN, DONE.
  - IDLE: motor_n = all 1s.
    - released rise (released & ~released_q) -> PATTERN.
    - Else data == KEY_CH0 or KEY_ALL -> MANUAL.
  - MANUAL, registered outputs, 1-cycle latency from data:
    - KEY_CH0 -> channel 0 on.
    - KEY_ALL -> all channels on.
    - Any other code -> all off, return to IDLE.
    - released rise -> PATTERN, taking priority over data.
  - PATTERN: step and period counters cleared on entry; busy = 1.
    - Channel i is on iff ch_en[i] and ph_i is in [ON_START, ON_END], where ph_i = (step + i*PHASE_STEP) mod PERIOD.
    - The mod is precomputed as constant offsets plus a compare-and-subtract; no runtime divider.
    - On tick: step increments. If step == PERIOD-1 it wraps to 0 and period increments.
    - If the step would wrap with period == REPEATS-1 -> DONE.
    - data is ignored in PATTERN.
  - DONE: motor_n = all 1s, done = 1 for exactly one cycle, then -> IDLE.
    - A new run requires released to fall and rise again.
- Abort: released = 0 in PATTERN -> IDLE next cycle; outputs all off; no done pulse.
  - Abort beats a simultaneous tick or completion.
- Widths:
  - step = clog2(PERIOD) bits, period = clog2(REPEATS+1) bits, prescaler = clog2(CLK_DIV) bits.
  - All compares unsigned.
- ch_en is sampled every cycle. Deasserting a channel mid-run turns it off next cycle without disturbing the counters.
- motor_n is a registered output; no combinational path from inputs.

Decomposition:
- Package motor_pkg:
  - KEY_CH0 = 8'h1d, KEY_ALL = 8'h15.
  - State enum {IDLE, MANUAL, PATTERN, DONE}.
  - MOTOR_ON = 1'b0, MOTOR_OFF = 1'b1.
- Sub-module tick_gen:
  - Parameter CLK_DIV.
  - Ports clk, rst_n, clr, tick.
  - Instantiated once for the prescaler.

Test Plan:
- Reset: rst_n = 0 mid-PATTERN with motors on -> motor_n = 3'b111 and busy = 0 asynchronously; state IDLE after release.
- Manual: data = 8'h1d -> motor_n = 3'b110 one cycle later. data = 8'h15 -> 3'b000. data = 8'h00 -> 3'b111 and IDLE.
- Pattern run (CLK_DIV=4, PERIOD=4, ON_START=1, ON_END=2, REPEATS=2, PHASE_STEP=0):
  - released rise -> busy = 1.
  - motor_n = 000 during steps 1-2 and 111 during steps 0 and 3, each step 4 cycles long.
  - done pulses once after 32 cycles; busy = 0.
- Phase stagger (same config, PHASE_STEP=1): channels 0/1/2 on-windows start at steps 1/0/3, with channel 2 wrapping across the period boundary.
- Abort: released falls at step 2 -> motor_n = 111 next cycle, IDLE, no done pulse. Holding released high after DONE does not restart a run.
- Channel enable: ch_en = 3'b101 during a run -> motor_n[1] stays 1 throughout; channels 0 and 2 follow the pattern unchanged.
